// File: rtl/reg_scoreboard_decoder.sv
// Register write-enable decoder with a per-register busy scoreboard.
// Stalls issue on RAW/WAW hazards and lets a same-cycle writeback release a stall.
module reg_scoreboard_decoder #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic [IDX_W-1:0]    iss_dst,
  input  logic [IDX_W-1:0]    iss_src_a,
  input  logic [IDX_W-1:0]    iss_src_b,
  output logic                iss_ready,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_cnt,
  output logic                err
);

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  // Out-of-range indices decode to all zeros, so they never read as busy.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return idx_valid(idx) ? (one << idx) : '0;
  endfunction

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] eff_busy;
  logic                hz;

  always_comb begin
    wb_clear  = wb_valid ? onehot(wb_idx) : '0;
    eff_busy  = busy_q & ~wb_clear;
    hz        = |(eff_busy & (onehot(iss_src_a) | onehot(iss_src_b) | onehot(iss_dst)));
    iss_ready = en & ~flush & iss_valid & idx_valid(iss_dst) & ~hz;

    // Issue set is ORed after the writeback clear so a same-index set wins.
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~wb_clear) | (iss_ready ? onehot(iss_dst) : '0);
    end

    cnt_d   = CNT_W'($countones(busy_d));
    wr_en_d = wb_clear;
    err_d   = (iss_valid & en & ~idx_valid(iss_dst)) | (wb_valid & ~idx_valid(wb_idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      wr_en_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy     = busy_q;
  assign wr_en    = wr_en_q;
  assign busy_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
// Drives a 16-register and a 12-register scoreboard from shared stimulus and
// compares both against a behavioural model through an expected-result queue.
module tb_reg_scoreboard_decoder;

  logic       clk = 1'b0;
  logic       rst, en, flush, iss_valid, wb_valid;
  logic [7:0] iss_dst, iss_src_a, iss_src_b, wb_idx;

  logic        ready16, err16;
  logic [15:0] wr16, busy16;
  logic [4:0]  cnt16;
  logic        ready12, err12;
  logic [11:0] wr12, busy12;
  logic [3:0]  cnt12;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] mb16 = '0;
  logic [15:0] mb12 = '0;

  typedef struct {
    logic [15:0] b16;
    logic [15:0] w16;
    logic        e16;
    logic [15:0] b12;
    logic [15:0] w12;
    logic        e12;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_scoreboard_decoder #(.NUM_REGS(16), .IDX_W(8), .CNT_W(5)) dut16 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
    .iss_ready(ready16), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .wr_en(wr16), .busy(busy16), .busy_cnt(cnt16), .err(err16)
  );

  reg_scoreboard_decoder #(.NUM_REGS(12), .IDX_W(8), .CNT_W(4)) dut12 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
    .iss_ready(ready12), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .wr_en(wr12), .busy(busy12), .busy_cnt(cnt12), .err(err12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bitv(input int i, input int n);
    return (i < n) ? (16'h1 << i) : 16'h0;
  endfunction

  // Reference behaviour for an n-register scoreboard, held in 16 bits.
  task automatic model(input logic [15:0] mb, input int n, input logic r, e, f, iv,
                       input int dst, sa, sb, input logic wv, input int wi,
                       output logic rdy, output logic [15:0] nb, output logic [15:0] wr,
                       output logic er);
    logic [15:0] rel, eff;
    rel = wv ? bitv(wi, n) : 16'h0;
    eff = mb & ~rel;
    rdy = e && !f && iv && (dst < n) && ((eff & (bitv(sa, n) | bitv(sb, n) | bitv(dst, n))) == 0);
    if (r) begin
      nb = '0; wr = '0; er = 1'b0;
    end else begin
      nb = f ? 16'h0 : ((mb & ~rel) | (rdy ? bitv(dst, n) : 16'h0));
      wr = rel;
      er = (iv && e && dst >= n) || (wv && wi >= n);
    end
  endtask

  task automatic step(input logic r, e, f, iv, input int dst, sa, sb,
                      input logic wv, input int wi);
    logic rdy16, rdy12;
    exp_t x;
    rst = r; en = e; flush = f; iss_valid = iv; wb_valid = wv;
    iss_dst = 8'(dst); iss_src_a = 8'(sa); iss_src_b = 8'(sb); wb_idx = 8'(wi);
    model(mb16, 16, r, e, f, iv, dst, sa, sb, wv, wi, rdy16, x.b16, x.w16, x.e16);
    model(mb12, 12, r, e, f, iv, dst, sa, sb, wv, wi, rdy12, x.b12, x.w12, x.e12);
    #1;
    if (!r) begin
      chk("ready16", {31'b0, ready16}, {31'b0, rdy16});
      chk("ready12", {31'b0, ready12}, {31'b0, rdy12});
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("busy16", {16'b0, busy16}, {16'b0, x.b16});
    chk("wr16",   {16'b0, wr16},   {16'b0, x.w16});
    chk("cnt16",  {27'b0, cnt16},  32'($countones(x.b16)));
    chk("err16",  {31'b0, err16},  {31'b0, x.e16});
    chk("busy12", {20'b0, busy12}, {16'b0, x.b12});
    chk("wr12",   {20'b0, wr12},   {16'b0, x.w12});
    chk("cnt12",  {28'b0, cnt12},  32'($countones(x.b12)));
    chk("err12",  {31'b0, err12},  {31'b0, x.e12});
    mb16 = x.b16;
    mb12 = x.b12;
  endtask

  initial begin
    // Reset and first issue.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", {16'b0, busy16}, 32'h0);
    chk("rst_wr", {16'b0, wr16}, 32'h0);
    step(0, 1, 0, 1, 3, 0, 0, 0, 0);
    chk("issue3_busy", {16'b0, busy16}, 32'h0008);
    chk("issue3_cnt", {27'b0, cnt16}, 32'd1);

    // RAW stall, then bypass by same-cycle writeback.
    step(0, 1, 0, 1, 7, 3, 0, 0, 0);
    chk("raw_stall_busy", {16'b0, busy16}, 32'h0008);
    step(0, 1, 0, 1, 7, 3, 0, 1, 3);
    chk("bypass_wr", {16'b0, wr16}, 32'h0008);
    chk("bypass_busy", {16'b0, busy16}, 32'h0080);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_wr", {16'b0, wr16}, 32'h0);

    // WAW on register 5 with set-wins.
    step(0, 1, 0, 1, 5, 0, 0, 0, 0);
    step(0, 1, 0, 1, 5, 0, 0, 1, 5);
    chk("waw_busy", {16'b0, busy16}, 32'h00A0);
    chk("waw_wr", {16'b0, wr16}, 32'h0020);
    chk("waw_cnt", {27'b0, cnt16}, 32'd2);

    // Out-of-range indices.
    step(0, 1, 0, 1, 8'h12, 0, 0, 0, 0);
    chk("oor_dst_err", {31'b0, err16}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, 1, 8'hF0);
    chk("oor_wb_wr", {16'b0, wr16}, 32'h0);
    chk("oor_wb_err", {31'b0, err16}, 32'd1);
    step(0, 1, 0, 1, 15, 0, 0, 0, 0);
    chk("idx15_busy", {16'b0, busy16}, 32'h80A0);
    chk("idx15_err12", {31'b0, err12}, 32'd1);

    // Fill, flush with writeback, then enable gating.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, i, i, i, 0, 0);
    chk("fill_busy", {16'b0, busy16}, 32'hFFFF);
    chk("fill_cnt", {27'b0, cnt16}, 32'd16);
    chk("fill_cnt12", {28'b0, cnt12}, 32'd12);
    step(0, 1, 1, 1, 1, 0, 0, 1, 2);
    chk("flush_busy", {16'b0, busy16}, 32'h0);
    chk("flush_wr", {16'b0, wr16}, 32'h0004);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("en0_busy", {16'b0, busy16}, 32'h0);

    // Non-power-of-two decode boundaries and reset with busy state.
    step(0, 1, 0, 0, 0, 0, 0, 1, 11);
    chk("np2_wr11", {20'b0, wr12}, 32'h0800);
    step(0, 1, 0, 0, 0, 0, 0, 1, 12);
    chk("np2_wr12", {20'b0, wr12}, 32'h0);
    chk("np2_err12", {31'b0, err12}, 32'd1);
    chk("np2_wr16", {16'b0, wr16}, 32'h1000);
    step(0, 1, 0, 1, 4, 0, 0, 0, 0);
    step(0, 1, 0, 1, 9, 0, 0, 1, 10);
    chk("pre_rst_busy12", {20'b0, busy12}, 32'h0210);
    step(1, 1, 0, 1, 6, 0, 0, 1, 4);
    chk("rst_busy12", {20'b0, busy12}, 32'h0);
    chk("rst_wr12", {20'b0, wr12}, 32'h0);
    chk("rst_cnt12", {28'b0, cnt12}, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
